// File: rtl/simple_uart_tx.sv
// ----------------------------------------------------------------------------
// simple_uart_tx
//
// Memory-mapped 8N1 serial transmitter for the Simple CPU bus. Bytes stored to
// BASE are queued in a small FIFO and shifted out LSB first on tx. A status
// word at STATUS lets software poll for space. A store to STATUS clears the
// sticky overflow flag.
//
// Ports:
//   clock        in   1   single clock, all state changes on posedge
//   reset        in   1   asynchronous, active-low; clears all state
//   address_bus  in  16   CPU address bus
//   ram_write    in   1   CPU store strobe
//   data_in      in  16   store data; [7:0] is the byte for BASE writes
//   data_out     out 16   status readback, zero unless data_oe is high
//   data_oe      out  1   high while STATUS is being read (bus tristate enable)
//   tx           out  1   serial line, idle high
//   busy         out  1   frame on the line or bytes still queued
//
// Status word: {11'b0, overflow, full, empty, tx_active, 1'b0}
// ----------------------------------------------------------------------------
module simple_uart_tx #(
    parameter logic [15:0] BASE         = 16'hFF10,
    parameter logic [15:0] STATUS       = 16'hFF12,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_bus,
    input  logic        ram_write,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        tx,
    output logic        busy
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] baud_reg,  baud_next;
    logic [2:0]  bit_reg,   bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        tx_reg,    tx_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        overflow_reg;
    logic [7:0]  fifo_mem [DEPTH];

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        overflow_set;
    logic        overflow_clr;
    logic        tx_active;
    logic        data_hi_unused;

    // Only the low byte of a store is transmitted.
    assign data_hi_unused = ^data_in[15:8];

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    // A pop on the same edge frees the slot, so a store to a full FIFO is
    // still accepted in that case.
    assign push_req     = ram_write && (address_bus == BASE);
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign overflow_clr = ram_write && (address_bus == STATUS);

    // Storage has no reset: contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= data_in[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            // Set has priority over a simultaneous clear.
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Transmit FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // Transmit FSM next-state logic. Each bit ends on the edge where the baud
    // counter reads zero, giving CLKS_PER_BIT cycles per bit.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == 16'd0) begin
                    tx_next    = shift_reg[0];
                    bit_next   = 3'd0;
                    baud_next  = BAUD_RELOAD;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (baud_reg == 16'd0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (baud_reg == 16'd0) begin
                    // Chain straight into the next start bit with no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        baud_next  = BAUD_RELOAD;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx_active = (state_reg != IDLE);
    assign tx        = tx_reg;
    assign busy      = tx_active || !fifo_empty;

    assign data_oe  = (address_bus == STATUS) && !ram_write;
    assign data_out = data_oe ? {11'b0, overflow_reg, fifo_full, fifo_empty, tx_active, 1'b0}
                              : 16'h0000;

endmodule

// File: tb/tb_simple_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_simple_uart_tx
//
// Self-checking bench for simple_uart_tx (CLKS_PER_BIT=4, DEPTH=8). A frame-
// level model (byte queue plus a frame-time counter) predicts tx, busy and the
// status word every cycle; directed scenarios pin the model with literal
// waveforms and status values, then randomized traffic exercises the rest.
// ----------------------------------------------------------------------------
module tb_simple_uart_tx;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] BASE   = 16'hFF10;
    localparam logic [15:0] STATUS = 16'hFF12;
    localparam int          FRAME  = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address_bus = 16'h0000;
    logic        ram_write = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_oe;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    simple_uart_tx #(
        .BASE        (BASE),
        .STATUS      (STATUS),
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address_bus(address_bus),
        .ram_write  (ram_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: queue of pending bytes, and the position (in
    // clock cycles) within the frame currently on the line.
    // ------------------------------------------------------------------
    byte unsigned mq[$];
    bit           m_active = 1'b0;
    int           m_t = 0;
    logic [7:0]   m_byte = 8'h00;
    bit           m_ovf = 1'b0;
    bit           mp_pop, mp_full, mp_set;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                m_active = 1'b0;
                m_t      = 0;
                m_ovf    = 1'b0;
            end else begin
                mp_full = (mq.size() == DEPTH);
                mp_pop  = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
                mp_set  = 1'b0;
                if (m_active) begin
                    m_t++;
                    if (m_t == FRAME) m_active = 1'b0;
                end
                if (mp_pop) begin
                    m_byte   = mq.pop_front();
                    m_active = 1'b1;
                    m_t      = 0;
                end
                if (ram_write && address_bus == BASE) begin
                    if (!mp_full || mp_pop) mq.push_back(data_in[7:0]);
                    else mp_set = 1'b1;
                end
                if (ram_write && address_bus == STATUS) m_ovf = 1'b0;
                if (mp_set) m_ovf = 1'b1;
            end
        end
    end

    function automatic logic model_tx();
        int bi;
        if (!m_active) return 1'b1;
        bi = m_t / CPB;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return m_byte[bi-1];
    endfunction

    function automatic logic [15:0] model_status();
        return {11'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), m_active, 1'b0};
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        logic exp_oe;
        forever begin
            @(negedge clock);
            exp_oe = (address_bus == STATUS) && !ram_write;
            chk("model_tx", {15'b0, tx}, {15'b0, model_tx()});
            chk("model_busy", {15'b0, busy}, {15'b0, (m_active || mq.size() > 0)});
            chk("model_oe", {15'b0, data_oe}, {15'b0, exp_oe});
            chk("model_status", data_out, exp_oe ? model_status() : 16'h0000);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a posedge.
    // ------------------------------------------------------------------
    logic stx   [80];
    logic sbusy [80];

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [15:0] a, input logic [15:0] d);
        ram_write   = we;
        address_bus = a;
        data_in     = d;
        if (we) $display("store addr=%h data=%h cyc=%0d", a, d, cyc);
        settle();
    endtask

    task automatic idle();
        ram_write   = 1'b0;
        address_bus = 16'h0000;
        data_in     = 16'h0000;
    endtask

    task automatic sample(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            stx[j]   = tx;
            sbusy[j] = busy;
        end
        settle();
    endtask

    task automatic read_status(input string name, input logic [15:0] exp);
        ram_write   = 1'b0;
        address_bus = STATUS;
        @(negedge clock);
        chk({name, "_oe"}, {15'b0, data_oe}, 16'h0001);
        chk(name, data_out, exp);
        settle();
        idle();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000 && busy; i++) settle();
        chk(name, {15'b0, busy}, 16'h0000);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) settle();
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios then randomized traffic
    // ------------------------------------------------------------------
    initial begin
        logic [9:0] pat55;
        logic [9:0] pata3;
        logic [9:0] pat01;
        int         n0;
        int         r;
        pat55 = 10'b1010101010;
        pata3 = 10'b1101000110;
        pat01 = 10'b1000000010;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_tx", {15'b0, tx}, 16'h0001);
        chk("reset_busy", {15'b0, busy}, 16'h0000);
        reset = 1'b1;
        settle();
        read_status("idle_status", 16'h0004);

        // Non-status addresses and status writes never drive the bus.
        address_bus = BASE;
        #1;
        chk("oe_base_read", {15'b0, data_oe}, 16'h0000);
        chk("out_base_read", data_out, 16'h0000);
        address_bus = 16'hFF11;
        #1;
        chk("oe_other_read", {15'b0, data_oe}, 16'h0000);
        ram_write   = 1'b1;
        address_bus = STATUS;
        #1;
        chk("oe_status_write", {15'b0, data_oe}, 16'h0000);
        idle();
        settle();

        // Single frame of 0x55
        drive(1'b1, BASE, 16'h0055);
        idle();
        sample(42);
        chk("t1_pre_tx", {15'b0, stx[0]}, 16'h0001);
        chk("t1_pre_busy", {15'b0, sbusy[0]}, 16'h0001);
        for (int b = 0; b < 10; b++)
            chk($sformatf("t1_bit%0d", b), {15'b0, stx[1 + 4*b + 2]}, {15'b0, pat55[b]});
        chk("t1_fall", {15'b0, stx[1]}, 16'h0000);
        chk("t1_busy_last", {15'b0, sbusy[40]}, 16'h0001);
        chk("t1_busy_drop", {15'b0, sbusy[41]}, 16'h0000);

        // Back-to-back frames 0xA3, 0x01
        drive(1'b1, BASE, 16'h00A3);
        drive(1'b1, BASE, 16'h0001);
        idle();
        sample(80);
        for (int b = 0; b < 10; b++)
            chk($sformatf("t2a_bit%0d", b), {15'b0, stx[4*b + 2]}, {15'b0, pata3[b]});
        chk("t2_stop_end", {15'b0, stx[39]}, 16'h0001);
        chk("t2_second_start", {15'b0, stx[40]}, 16'h0000);
        for (int b = 0; b < 10; b++)
            chk($sformatf("t2b_bit%0d", b), {15'b0, stx[40 + 4*b + 2]}, {15'b0, pat01[b]});
        wait_idle("t2_drain");

        // Overflow burst: 10 stores, 9 accepted
        n0 = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, BASE, 16'(8'h10 + i));
            if (i == 0) n0 = cyc;
        end
        idle();
        read_status("ovf_status", 16'h001A);
        drive(1'b1, STATUS, 16'h0000);
        idle();
        read_status("ovf_cleared", 16'h000A);

        // Store to a full FIFO on the exact edge the first stop bit completes
        wait_cyc(n0 + FRAME);
        drive(1'b1, BASE, 16'h00C3);
        idle();
        read_status("full_pop_store", 16'h000A);
        wait_idle("t5_drain");

        // Reset during DATA bit 3 of a 0x00 frame, with a byte queued behind it
        drive(1'b1, BASE, 16'h0000);
        n0 = cyc;
        drive(1'b1, BASE, 16'h005A);
        idle();
        wait_cyc(n0 + 18);
        chk("rst_pre_tx", {15'b0, tx}, 16'h0000);
        reset = 1'b0;
        #1;
        chk("rst_async_tx", {15'b0, tx}, 16'h0001);
        chk("rst_async_busy", {15'b0, busy}, 16'h0000);
        repeat (3) settle();
        reset = 1'b1;
        repeat (2) settle();
        chk("rst_after_busy", {15'b0, busy}, 16'h0000);
        read_status("rst_status", 16'h0004);
        repeat (20) settle();
        chk("rst_no_frame", {15'b0, tx}, 16'h0001);

        // Randomized traffic, checked against the model every cycle
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                drive(1'b1, BASE, 16'($urandom));
            end else if (r == 5) begin
                drive(1'b1, STATUS, 16'($urandom));
            end else if (r == 6) begin
                drive(1'b0, STATUS, 16'h0000);
            end else if (r == 7) begin
                drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            end else begin
                idle();
                repeat ($urandom_range(0, 60)) settle();
            end
        end
        idle();
        wait_idle("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_uart_tx.md
# simple_uart_tx

Memory-mapped serial transmitter on the Simple CPU system bus, downstream of the CPU's store path and alongside the debug output ports at 16'hFF01–16'hFF03. The CPU writes bytes with ordinary `st`/`sto` instructions. The block queues them in a small FIFO and shifts each one out as an 8N1 asynchronous serial frame on `tx`. A status word is readable at a second address so software can poll for space.

## Interface
- `BASE`, 16'hFF10: data register address. A write here enqueues a byte.
- `STATUS`, 16'hFF12: status register address. A read returns status; a write clears `overflow`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, legal range 2–65535.
- `DEPTH`, 8: FIFO entries, a power of two from 2 to 64.

Ports:
- `clock`, in, 1: the only clock. All state changes on posedge.
- `reset`, in, 1: asynchronous, active-low. Clears all state immediately while low.
- `address_bus`, in, 16: CPU address bus.
- `ram_write`, in, 1: CPU write strobe. High means the current cycle is a store.
- `data_in`, in, 16: store data from the bus. Bits [7:0] are used for `BASE` writes.
- `data_out`, out, 16: status readback value.
- `data_oe`, out, 1: high when `data_out` must drive the shared bus. The top level tristates on this.
- `tx`, out, 1: serial output, idle high.
- `busy`, out, 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- Enqueue: on a posedge with `ram_write`=1 and `address_bus`==`BASE`, push `data_in[7:0]` into the FIFO.
  - If the FIFO is full and no pop occurs on that edge, drop the byte and set sticky `overflow`.
  - If the FIFO is full and a pop occurs on the same edge, accept the write.
- Status write: `ram_write`=1 and `address_bus`==`STATUS` clears `overflow`. If an overflow event occurs on the same edge, the set wins.
- Status read: combinational.
  - `data_oe` = (`address_bus`==`STATUS`) && !`ram_write`.
  - `data_out` = {11'b0, `overflow`, `full`, `empty`, `tx_active`, 1'b0}.
  - `data_out` is 0 whenever `data_oe` is low.
- FIFO: circular buffer with pointers one bit wider than log2(`DEPTH`); the pointers wrap modulo 2·`DEPTH`.
  - `full` = (pointer MSBs differ and low bits are equal).
  - `empty` = (pointers are equal).
- Transmit FSM, with states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty at a posedge, pop the head into the 8-bit shift register, drive `tx`<=0, go to START, and load the baud counter.
  - START: hold `tx`=0 for `CLKS_PER_BIT` cycles. Then `tx`<=shift[0], bit counter=0, go to DATA.
  - DATA: each bit is held `CLKS_PER_BIT` cycles, sent LSB first.
    - After bit 7 completes, `tx`<=1 and go to STOP.
    - Otherwise shift right and drive the next bit.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. At completion:
    - If the FIFO is non-empty, pop, drive `tx`<=0, and go to START. There is no idle gap.
    - Otherwise go to IDLE.
- Baud counter: counts down from `CLKS_PER_BIT`-1 to 0. The bit ends on the edge where the counter is 0.
- `tx_active` = state != IDLE.
- `busy` = `tx_active` || !`empty`.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, state=IDLE, FIFO empty, pointers 0, `overflow`=0.
  - `data_out`/`data_oe` follow the address combinationally, so they are 0 unless `STATUS` is being read.
- Reset asserted mid-frame aborts the frame: `tx` goes high immediately and queued bytes are discarded.
- Latency:
  - Write captured at edge N into an empty FIFO while IDLE: the byte is popped and `tx` falls at edge N+1.
  - Frame length is exactly 10·`CLKS_PER_BIT` cycles, from the `tx` falling edge to the end of the stop bit.
  - Back-to-back frames have start bits exactly 10·`CLKS_PER_BIT` apart.
- Status reflects registered state, so it changes one edge after the triggering write or pop.
- `ram_write` is sampled every edge; a store held high for multiple cycles enqueues once per cycle. The CPU's store path holds the strobe for exactly one cycle.

## Test plan
- Reset, then store 16'h0055 to 16'hFF10 with `CLKS_PER_BIT`=4 -> `tx` falls one edge later and shows 0,1,0,1,0,1,0,1,0,1, 4 cycles per bit. `busy` stays high for 40 cycles, then drops.
- Store 16'h00A3 then 16'h0001 on consecutive cycles -> two frames with start bits 40 cycles apart; the second frame's data bits are 1,0,0,0,0,0,0,0.
- Store 10 bytes on consecutive cycles with `DEPTH`=8 -> 9 are accepted (the first is popped immediately) and the 10th is dropped. A `STATUS` read returns `overflow`=1, `full`=1. Storing to `STATUS` clears `overflow` on the next edge.
- Read `STATUS` in idle -> `data_oe`=1 and `data_out`=16'h0004 (`empty`). Reading any other address -> `data_oe`=0.
- With the FIFO full, store on the exact edge the STOP bit completes -> the write is accepted and `overflow` stays 0.
- Assert `reset` low during DATA bit 3 -> `tx`=1 asynchronously. After release, `busy`=0 and a `STATUS` read returns 16'h0004.
